// File: rtl/conv_pkg.sv
// conv_pkg: shared types and constant helpers for the convolution engine.
//   conv_state_e : control FSM state encoding
//   acc_width()  : accumulator width that cannot overflow for a K*K dot product
//   out_dim()    : valid (unpadded) output extent along one axis
package conv_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoadk,
    StFetch,
    StDrain,
    StWrite,
    StDone
  } conv_state_e;

  function automatic int acc_width(input int data_w, input int ksize);
    return 2 * data_w + $clog2(ksize * ksize);
  endfunction

  function automatic int out_dim(input int img, input int k, input int stride);
    return (img - k) / stride + 1;
  endfunction

endpackage

// File: rtl/conv_engine_if.sv
// conv_engine_if: control and memory bus of the convolution engine.
//   start/relu/x_base/w_base/z_base : job request (sampled in idle)
//   rd_en/rd_addr -> rd_data         : memory read, data valid the cycle after rd_en
//   wr_en/wr_addr/wr_data            : memory write
//   busy/done                        : job status
// modport master: the engine side; modport slave: the environment side.
interface conv_engine_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic                     start;
  logic                     relu;
  logic        [ADDR_W-1:0] x_base;
  logic        [ADDR_W-1:0] w_base;
  logic        [ADDR_W-1:0] z_base;
  logic                     rd_en;
  logic        [ADDR_W-1:0] rd_addr;
  logic signed [DATA_W-1:0] rd_data;
  logic                     wr_en;
  logic        [ADDR_W-1:0] wr_addr;
  logic signed [DATA_W-1:0] wr_data;
  logic                     busy;
  logic                     done;

  modport master (
    input  start, relu, x_base, w_base, z_base, rd_data,
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done
  );

  modport slave (
    output start, relu, x_base, w_base, z_base, rd_data,
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done
  );
endinterface

// File: rtl/conv_mac.sv
// conv_mac: signed multiply-accumulate with synchronous clear and a
// saturating / ReLU output stage.
//   clk, rst_n : clock, async active-low reset
//   i_clear    : zero the accumulator (wins over i_en)
//   i_en       : add i_pix * i_wgt to the accumulator
//   i_relu     : force negative results to 0
//   o_result   : accumulator saturated to the signed DATA_W range
module conv_mac
  import conv_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int KSIZE  = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_clear,
  input  logic                     i_en,
  input  logic                     i_relu,
  input  logic signed [DATA_W-1:0] i_pix,
  input  logic signed [DATA_W-1:0] i_wgt,
  output logic signed [DATA_W-1:0] o_result
);

  localparam int AccW = acc_width(DATA_W, KSIZE);

  localparam logic signed [AccW-1:0] SatMax = {{(AccW - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [AccW-1:0] SatMin = {{(AccW - DATA_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}};

  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [AccW-1:0]     w_prod_ext;
  logic signed [AccW-1:0]     r_acc;

  assign w_prod     = i_pix * i_wgt;
  assign w_prod_ext = AccW'(w_prod);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc + w_prod_ext;
    end
  end

  always_comb begin
    o_result = r_acc[DATA_W-1:0];
    if (i_relu && r_acc[AccW-1]) begin
      o_result = '0;
    end else if (r_acc > SatMax) begin
      o_result = {1'b0, {(DATA_W - 1){1'b1}}};
    end else if (r_acc < SatMin) begin
      o_result = {1'b1, {(DATA_W - 1){1'b0}}};
    end
  end

endmodule

// File: rtl/conv_engine.sv
// conv_engine: valid (unpadded) 2-D convolution of an IMG_H x IMG_W image with
// a KSIZE x KSIZE kernel, both read from memory, results written row-major.
//   clk, rst_n : clock, async active-low reset
//   bus        : conv_engine_if.master (job request, memory read/write, busy/done)
// Per job: K*K+1 cycles to load weights, then K*K fetch + 1 drain + 1 write
// cycles per output, then a single done cycle.
module conv_engine
  import conv_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int KSIZE  = 3,
  parameter int IMG_W  = 5,
  parameter int IMG_H  = 5,
  parameter int STRIDE = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  conv_engine_if.master bus
);

  localparam int KK   = KSIZE * KSIZE;
  localparam int OH   = out_dim(IMG_H, KSIZE, STRIDE);
  localparam int OW   = out_dim(IMG_W, KSIZE, STRIDE);
  localparam int CntW = $clog2(KK + 1);
  localparam int KW   = $clog2(KSIZE + 1);
  localparam int OrW  = $clog2(OH + 1);
  localparam int OcW  = $clog2(OW + 1);

  conv_state_e r_state, w_state_next;

  logic [CntW-1:0]   r_cnt;
  logic [KW-1:0]     r_ki, r_kj;
  logic [OrW-1:0]    r_orow;
  logic [OcW-1:0]    r_ocol;
  logic [ADDR_W-1:0] r_xb, r_wb, r_zb;
  logic              r_relu;

  // Weight file is a circular shift register: the tap in use is always
  // entry 0, so no indexed read is needed and K*K rotations restore order.
  logic signed [DATA_W-1:0] r_wgt [KK];

  logic                     w_load_done, w_last_tap, w_last_out;
  logic                     w_mac_clear, w_mac_en, w_wgt_load, w_wgt_shift;
  logic signed [DATA_W-1:0] w_mac_out;

  assign w_load_done = (r_cnt == CntW'(KK));
  assign w_last_tap  = (r_cnt == CntW'(KK - 1));
  assign w_last_out  = (r_orow == OrW'(OH - 1)) && (r_ocol == OcW'(OW - 1));

  // rd_data lags rd_en by one cycle, so tap n is consumed while tap n+1 is read.
  assign w_wgt_load  = (r_state == StLoadk) && (r_cnt != '0);
  assign w_mac_clear = (r_state == StFetch) && (r_cnt == '0);
  assign w_mac_en    = ((r_state == StFetch) && (r_cnt != '0)) || (r_state == StDrain);
  assign w_wgt_shift = w_wgt_load || w_mac_en;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (bus.start) w_state_next = StLoadk;
      StLoadk: if (w_load_done) w_state_next = StFetch;
      StFetch: if (w_last_tap) w_state_next = StDrain;
      StDrain: w_state_next = StWrite;
      StWrite: w_state_next = w_last_out ? StDone : StFetch;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Job parameters and loop counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_ki   <= '0;
      r_kj   <= '0;
      r_orow <= '0;
      r_ocol <= '0;
      r_xb   <= '0;
      r_wb   <= '0;
      r_zb   <= '0;
      r_relu <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (bus.start) begin
            r_xb   <= bus.x_base;
            r_wb   <= bus.w_base;
            r_zb   <= bus.z_base;
            r_relu <= bus.relu;
            r_cnt  <= '0;
            r_ki   <= '0;
            r_kj   <= '0;
            r_orow <= '0;
            r_ocol <= '0;
          end
        end
        StLoadk: r_cnt <= w_load_done ? '0 : r_cnt + CntW'(1);
        StFetch: begin
          r_cnt <= w_last_tap ? '0 : r_cnt + CntW'(1);
          if (r_kj == KW'(KSIZE - 1)) begin
            r_kj <= '0;
            r_ki <= (r_ki == KW'(KSIZE - 1)) ? '0 : r_ki + KW'(1);
          end else begin
            r_kj <= r_kj + KW'(1);
          end
        end
        StWrite: begin
          if (r_ocol == OcW'(OW - 1)) begin
            r_ocol <= '0;
            r_orow <= r_orow + OrW'(1);
          end else begin
            r_ocol <= r_ocol + OcW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Weight storage; contents are meaningless until a full load completes.
  always_ff @(posedge clk) begin
    if (w_wgt_shift) begin
      for (int i = 0; i < KK - 1; i++) begin
        r_wgt[i] <= r_wgt[i+1];
      end
      r_wgt[KK-1] <= w_wgt_load ? bus.rd_data : r_wgt[0];
    end
  end

  conv_mac #(
    .DATA_W (DATA_W),
    .KSIZE  (KSIZE)
  ) u_mac (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_mac_clear),
    .i_en     (w_mac_en),
    .i_relu   (r_relu),
    .i_pix    (bus.rd_data),
    .i_wgt    (r_wgt[0]),
    .o_result (w_mac_out)
  );

  // Outputs; address sums are truncated to ADDR_W so they wrap naturally.
  always_comb begin
    bus.rd_en   = 1'b0;
    bus.rd_addr = '0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.busy    = 1'b0;
    bus.done    = 1'b0;
    case (r_state)
      StLoadk: begin
        bus.busy = 1'b1;
        if (!w_load_done) begin
          bus.rd_en   = 1'b1;
          bus.rd_addr = r_wb + ADDR_W'(r_cnt);
        end
      end
      StFetch: begin
        bus.busy    = 1'b1;
        bus.rd_en   = 1'b1;
        bus.rd_addr = r_xb + ADDR_W'((32'(r_orow) * 32'(STRIDE) + 32'(r_ki)) * 32'(IMG_W)
                                     + 32'(r_ocol) * 32'(STRIDE) + 32'(r_kj));
      end
      StDrain: bus.busy = 1'b1;
      StWrite: begin
        bus.busy    = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_addr = r_zb + ADDR_W'(32'(r_orow) * 32'(OW) + 32'(r_ocol));
        bus.wr_data = w_mac_out;
      end
      StDone:  bus.done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/conv_engine.md
CONV_ENGINE -- requirements
Module: conv_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 8, pixel/weight/output width (signed two's complement).
REQ-002 SHALL have parameter ADDR_W, default 8, memory address width.
REQ-003 SHALL have parameter KSIZE, default 3, square kernel side K.
REQ-004 SHALL have parameters IMG_W and IMG_H, default 5 each, input image dimensions.
REQ-005 SHALL have parameter STRIDE, default 1, window step in both axes.
REQ-006 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port start, input, 1, request new convolution.
REQ-009 SHALL have port relu, input, 1, clamp negative results to 0; latched with start.
REQ-010 SHALL have ports x_base, w_base, z_base, input, ADDR_W each: image, kernel and output base addresses.
REQ-011 SHALL have ports rd_en (out, 1), rd_addr (out, ADDR_W), rd_data (in, DATA_W): memory read; rd_data valid the cycle after rd_en.
REQ-012 SHALL have ports wr_en (out, 1), wr_addr (out, ADDR_W), wr_data (out, DATA_W): memory write.
REQ-013 SHALL have ports busy (out, 1) and done (out, 1).

Function
REQ-014 SHALL implement FSM states IDLE, LOADK, FETCH, DRAIN, WRITE, DONE.
REQ-015 IDLE: start=1 at a clock edge latches x_base, w_base, z_base, relu and moves to LOADK; busy=1 from the next cycle until DONE exits.
REQ-016 start SHALL be ignored in every state except IDLE.
REQ-017 LOADK: K*K reads at w_base+i, i=0..K*K-1, one per cycle, plus one extra cycle to capture the last weight (K*K+1 cycles); weights stored row-major in an internal register file.
REQ-018 Output dimensions: OH=(IMG_H-K)/STRIDE+1, OW=(IMG_W-K)/STRIDE+1, floor division; valid (no padding) convolution.
REQ-019 FETCH: for output (r,c), K*K reads, one per cycle, at x_base+(r*STRIDE+i)*IMG_W+(c*STRIDE+j), i outer, j inner; accumulator cleared on entry.
REQ-020 DRAIN: one cycle accumulating the final read product; WRITE: one cycle with wr_en=1, wr_addr=z_base+r*OW+c; each output costs exactly K*K+2 cycles.
REQ-021 Outputs SHALL be processed row-major; after the last output FSM enters DONE.
REQ-022 Accumulator SHALL be signed, width 2*DATA_W+clog2(K*K), with no overflow.
REQ-023 wr_data SHALL saturate the accumulator to the signed DATA_W range; when relu=1, negative results SHALL write 0.
REQ-024 All address arithmetic SHALL be modulo 2^ADDR_W (wrap-around, no error).
REQ-025 DONE: done=1 for exactly one cycle, busy=0, then IDLE; start in DONE ignored.
REQ-026 done SHALL assert exactly 1+(K*K+1)+OH*OW*(K*K+2) cycles after the start-sampling edge.
REQ-027 rd_en and wr_en SHALL never be high in the same cycle; rd_addr/wr_addr/wr_data are 0 when their enable is low.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE and drive busy, done, rd_en, wr_en, rd_addr, wr_addr, wr_data to 0.
REQ-029 Reset mid-operation SHALL abort with no further write; weight register contents are don't-care after reset.

Structure
REQ-030 Package conv_pkg SHALL hold the FSM state enum and the accumulator-width and output-dimension constant functions.
REQ-031 Sub-module conv_mac SHALL implement signed multiply-accumulate with clear and saturate/ReLU output stage.

Verification (defaults: DATA_W=8, K=3, 5x5, STRIDE=1)
REQ-032 Image all 1, weights all 1, start one cycle -> nine writes of 9 to z_base..z_base+8; done 110 cycles after start edge.
REQ-033 Image all 127, weights all 127 -> every wr_data 127 (saturated); weights all -1, image all 1 -> 0xF7 with relu=0, 0x00 with relu=1.
REQ-034 STRIDE=2, image value = address index -> four writes at z_base..z_base+3, values matching a golden model.
REQ-035 start pulsed again while busy -> ignored; exactly nine writes and one done.
REQ-036 rst_n low during FETCH of output 4 -> all outputs 0 within same cycle, no further wr_en; new start runs full job correctly.
REQ-037 x_base=250 -> read addresses wrap through 0, results match golden model with modulo-256 addressing.
